// File: rtl/yin_sample_buffer.sv
// yin_sample_buffer: circular 2N-entry sample store for the YIN difference
// engine. Samples are written at the audio rate, analysis frames of
// N+MAX_TAU samples are published every N writes with a valid/ack
// handshake, and the engine reads back through a registered port with
// one-cycle latency (read-before-write on a same-entry collision).
// Optional build macro: YIN_SAMPLE_BUFFER_HOLD_EN -- when defined, writes
// are dropped instead of overwriting a frame the engine still owns.
module yin_sample_buffer #(
    parameter int DATA_WIDTH       = 8,
    parameter int WINDOW_SIZE_BITS = 8,
    parameter int MAX_TAU          = 40,
    parameter int ADDR_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] initial_address,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic                  frame_dropped,
    output logic                  overrun
);

    localparam int N         = 1 << WINDOW_SIZE_BITS;
    localparam int BUF       = 2 * N;
    localparam int PW        = WINDOW_SIZE_BITS + 1;
    localparam int FRAME_LEN = N + MAX_TAU;
    localparam int GUARD     = N - MAX_TAU;

    localparam logic [PW-1:0] FRAME_LEN_P = PW'(FRAME_LEN);
    localparam logic [PW-1:0] GUARD_P     = PW'(GUARD);
    localparam logic [PW-1:0] GUARD_SAT   = PW'(GUARD + 1);
    localparam logic [WINDOW_SIZE_BITS-1:0] HOP_LAST = {WINDOW_SIZE_BITS{1'b1}};

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_IDLE = 2'd2;

    logic [DATA_WIDTH-1:0] mem [0:BUF-1];

    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [WINDOW_SIZE_BITS-1:0] hop_cnt_q, hop_cnt_d;
    logic [PW-1:0]               guard_cnt_q, guard_cnt_d;
    logic [PW-1:0]               init_ptr_q, init_ptr_d;
    logic [1:0]                  state_q, state_d;
    logic                        first_hop_q, first_hop_d;
    logic                        dropped_q, dropped_d;
    logic                        overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]       data_q;

    logic busy;
    logic at_guard;
    logic wr_en;
    logic boundary;
    logic publish;

    // Address bits above the buffer index are deliberately ignored (implicit wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[ADDR_WIDTH-1:PW];

    assign busy     = (state_q == ST_BUSY);
    // The next write would touch the oldest sample of the protected frame.
    assign at_guard = busy && (guard_cnt_q == GUARD_P);

`ifdef YIN_SAMPLE_BUFFER_HOLD_EN
    assign wr_en = sample_valid && !at_guard;
`else
    assign wr_en = sample_valid;
`endif

    assign boundary = wr_en && (hop_cnt_q == HOP_LAST);
    // The first boundary after reset only completes half the buffer.
    assign publish  = boundary && ((state_q != ST_FILL) || first_hop_q);

    // Next-state logic: pointers, counters, frame handshake and status flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        hop_cnt_d   = hop_cnt_q;
        guard_cnt_d = guard_cnt_q;
        init_ptr_d  = init_ptr_q;
        state_d     = state_q;
        first_hop_d = first_hop_q;
        dropped_d   = 1'b0;
        overrun_d   = overrun_q | (at_guard && sample_valid);

        if (wr_en) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            hop_cnt_d = hop_cnt_q + 1'b1;
            if (busy && (guard_cnt_q != GUARD_SAT)) begin
                guard_cnt_d = guard_cnt_q + 1'b1;
            end
        end

        if (boundary && (state_q == ST_FILL)) begin
            first_hop_d = 1'b1;
        end

        if (publish) begin
            // A publish beats a coincident ack; only an unacked frame counts as dropped.
            state_d     = ST_BUSY;
            init_ptr_d  = wr_ptr_d - FRAME_LEN_P;
            guard_cnt_d = '0;
            dropped_d   = busy && !frame_ack;
        end else if (busy && frame_ack) begin
            state_d = ST_IDLE;
        end
    end

    // Sample memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    // Registered read port, old data returned on a same-entry write.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= mem[address[PW-1:0]];
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            hop_cnt_q   <= '0;
            guard_cnt_q <= '0;
            init_ptr_q  <= '0;
            state_q     <= ST_FILL;
            first_hop_q <= 1'b0;
            dropped_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            hop_cnt_q   <= hop_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            init_ptr_q  <= init_ptr_d;
            state_q     <= state_d;
            first_hop_q <= first_hop_d;
            dropped_q   <= dropped_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out        = data_q;
    assign initial_address = ADDR_WIDTH'(init_ptr_q);
    assign frame_valid     = busy;
    assign frame_dropped   = dropped_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_yin_sample_buffer.sv
// Testbench for yin_sample_buffer with N=16, BUF=32, MAX_TAU=4.
// Reference model works from total write counts and modular arithmetic.
module tb_yin_sample_buffer;

    logic        clk;
    logic        reset;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic [15:0] address;
    logic [7:0]  data_out;
    logic [15:0] initial_address;
    logic        frame_valid;
    logic        frame_ack;
    logic        frame_dropped;
    logic        overrun;

    int checks;
    int errors;

    yin_sample_buffer #(
        .DATA_WIDTH      (8),
        .WINDOW_SIZE_BITS(4),
        .MAX_TAU         (4),
        .ADDR_WIDTH      (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .address        (address),
        .data_out       (data_out),
        .initial_address(initial_address),
        .frame_valid    (frame_valid),
        .frame_ack      (frame_ack),
        .frame_dropped  (frame_dropped),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_mem [32];
    bit         m_known [32];
    int         m_wp;
    int         m_writes;
    int         m_since;
    bit         m_busy;
    int         m_init;
    bit         m_drop;
    bit         m_ovr;
    logic [7:0] m_data;
    bit         m_data_known;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wp = 0; m_writes = 0; m_since = 0;
        m_busy = 0; m_init = 0; m_drop = 0; m_ovr = 0;
        m_data = 8'h00; m_data_known = 1;
    endtask

    task automatic model_step(input logic v, input logic [7:0] s, input logic [15:0] a, input logic ack);
        int  idx;
        bit  accept;
        idx          = int'(a[4:0]);
        m_data       = m_mem[idx];
        m_data_known = m_known[idx];
        m_drop       = 0;
        accept       = v;
`ifdef YIN_SAMPLE_BUFFER_HOLD_EN
        if (v && m_busy && m_since >= 12) begin
            accept = 0;
            m_ovr  = 1;
        end
`endif
        if (accept) begin
            m_mem[m_wp]   = s;
            m_known[m_wp] = 1;
            m_wp          = (m_wp + 1) % 32;
            m_writes++;
            if (m_busy) begin
                m_since++;
                if (m_since > 12) m_ovr = 1;
            end
        end
        if (accept && m_writes >= 32 && (m_writes % 16) == 0) begin
            if (m_busy && !ack) m_drop = 1;
            m_busy  = 1;
            m_init  = (m_wp + 32 - 20) % 32;
            m_since = 0;
        end else if (ack && m_busy) begin
            m_busy = 0;
        end
    endtask

    task automatic check_all();
        chk("frame_valid", 32'(frame_valid), 32'(m_busy));
        chk("initial_address", 32'(initial_address), 32'(m_init));
        chk("frame_dropped", 32'(frame_dropped), 32'(m_drop));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_data_known) chk("data_out", 32'(data_out), 32'(m_data));
    endtask

    task automatic step(input logic v, input logic [7:0] s, input logic [15:0] a, input logic ack);
        sample_valid = v;
        sample_in    = s;
        address      = a;
        frame_ack    = ack;
        model_step(v, s, a, ack);
        @(posedge clk);
        #1;
        $display("t=%0t v=%0b s=%02h a=%04h ack=%0b : dout=%02h fv=%0b ia=%0d drop=%0b ovr=%0b",
                 $time, v, s, a, ack, data_out, frame_valid, initial_address, frame_dropped, overrun);
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_valid = 1'b0; frame_ack = 1'b0;
        sample_in = 8'h00; address = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        $display("t=%0t reset : dout=%02h fv=%0b ia=%0d drop=%0b ovr=%0b",
                 $time, data_out, frame_valid, initial_address, frame_dropped, overrun);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_initial_address", 32'(initial_address), 32'd0);
        chk("rst_frame_dropped", 32'(frame_dropped), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    initial begin
        int drops;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 8'h00;
            m_known[i] = 0;
        end
        reset = 1'b1; sample_valid = 1'b0; frame_ack = 1'b0;
        sample_in = 8'h00; address = 16'h0000;
        model_reset();
        @(posedge clk);
        #1;

        // Scenario 1: fill and first publish
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 8'(i), 16'd12, 1'b0);
            if (i < 31) chk("s1_no_early_frame", 32'(frame_valid), 32'd0);
        end
        chk("s1_valid", 32'(frame_valid), 32'd1);
        chk("s1_init", 32'(initial_address), 32'd12);
        step(1'b0, 8'h00, 16'd12, 1'b0);
        chk("s1_read12", 32'(data_out), 32'd12);

        // Scenario 2: read address wrap
        step(1'b0, 8'h00, 16'd31, 1'b0);
        chk("s2_read31", 32'(data_out), 32'd31);
        step(1'b0, 8'h00, 16'd32, 1'b0);
        chk("s2_read32", 32'(data_out), 32'd0);
        step(1'b0, 8'h00, 16'h0045, 1'b0);
        chk("s2_read45", 32'(data_out), 32'd5);

        // Scenario 3: ack, next hop, publish at 28
        step(1'b0, 8'h00, 16'd0, 1'b1);
        chk("s3_fall", 32'(frame_valid), 32'd0);
        for (int i = 32; i < 48; i++) step(1'b1, 8'(i), 16'd0, 1'b0);
        chk("s3_valid", 32'(frame_valid), 32'd1);
        chk("s3_init", 32'(initial_address), 32'd28);
        for (int a = 28; a < 48; a++) begin
            step(1'b0, 8'h00, 16'(a), 1'b0);
            chk("s3_frame_read", 32'(data_out), 32'(a));
        end

        // Scenario 4: guard exhaustion
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 16'd0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            step(1'b1, 8'(100 + i), 16'd0, 1'b0);
            if (i == 11) chk("s4_no_ovr_12", 32'(overrun), 32'd0);
        end
        chk("s4_ovr_13", 32'(overrun), 32'd1);
        step(1'b0, 8'h00, 16'd12, 1'b0);
`ifdef YIN_SAMPLE_BUFFER_HOLD_EN
        chk("s4_entry12", 32'(data_out), 32'd12);
`else
        chk("s4_entry12", 32'(data_out), 32'd112);
`endif

        // Scenario 5: unacked frame replaced on the next hop
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 16'd0, 1'b0);
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(200 + i), 16'd0, 1'b0);
            if (frame_dropped) drops++;
        end
        chk("s5_valid", 32'(frame_valid), 32'd1);
`ifdef YIN_SAMPLE_BUFFER_HOLD_EN
        chk("s5_drop_count", 32'(drops), 32'd0);
        chk("s5_init", 32'(initial_address), 32'd12);
`else
        chk("s5_drop_count", 32'(drops), 32'd1);
        chk("s5_init", 32'(initial_address), 32'd28);
`endif

        // Scenario 6: reset while BUSY
        do_reset();
        for (int i = 0; i < 31; i++) step(1'b1, 8'(50 + i), 16'(i), 1'b0);
        chk("s6_no_frame", 32'(frame_valid), 32'd0);
        step(1'b1, 8'd81, 16'd0, 1'b0);
        chk("s6_valid", 32'(frame_valid), 32'd1);
        chk("s6_init", 32'(initial_address), 32'd12);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            step(($urandom % 4) != 0, 8'($urandom), 16'($urandom), ($urandom % 20) == 0);
        end

        sample_valid = 1'b0;
        frame_ack    = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/yin_sample_buffer.md
Name: yin_sample_buffer

Overview:
- Circular sample store feeding the YIN difference engine (diff_module).
- Writes incoming audio samples at the sample rate (FS = 2000).
- Publishes analysis frames as initial_address with a valid/ack handshake.
- Answers the engine's random-access reads with a registered one-cycle-latency data port, matching the engine's read timing.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- WINDOW_SIZE_BITS, 8, N = 2^WINDOW_SIZE_BITS is both the integration window and the hop size.
- MAX_TAU, 40, largest lag the engine uses; legal range 1..N-1.
- ADDR_WIDTH, 16, read/initial address width, equal to the engine's address bus.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  DATA_WIDTH  incoming sample.
- sample_valid  in  1  write strobe; one sample per high cycle.
- address  in  ADDR_WIDTH  read address from the engine.
- data_out  out  DATA_WIDTH  registered read data.
- initial_address  out  ADDR_WIDTH  start address of the published frame.
- frame_valid  out  1  a frame is published and protected.
- frame_ack  in  1  engine has finished with the frame (1-cycle pulse).
- frame_dropped  out  1  1-cycle pulse: a pending frame was replaced.
- overrun  out  1  sticky: protected data was overwritten or dropped.

Behaviour:
- Storage:
  - BUF = 2N entries.
  - Write pointer wr_ptr is (WINDOW_SIZE_BITS+1) bits and wraps modulo BUF.
  - A write stores mem[wr_ptr] <= sample_in, then wr_ptr++.
- Read port:
  - data_out <= mem[address mod BUF] every cycle, one-cycle latency; no enable.
  - Address bits above WINDOW_SIZE_BITS are ignored, so wrap-around is implicit.
  - Read and write to the same entry in one cycle: data_out returns the old contents (read-before-write).
- Frame geometry:
  - FRAME_LEN = N + MAX_TAU samples.
  - The frame ends at the newest written sample.
  - initial_address = (wr_ptr_after_write − FRAME_LEN) mod BUF, zero-extended to ADDR_WIDTH.
  - Guard = BUF − FRAME_LEN = N − MAX_TAU writes may occur before protected data is touched.
- Hop counter: counts writes and wraps at N; a boundary occurs on the write that makes the count N.
- State machine:
  - FILL: after reset. On the 2nd hop boundary (2N total writes) → publish → BUSY.
  - BUSY: frame_valid=1. initial_address is stable. guard_cnt counts writes since publish.
    - frame_ack → IDLE; frame_valid falls on the next cycle.
    - Hop boundary with no ack: republish with the new initial_address, pulse frame_dropped, stay in BUSY, clear guard_cnt.
  - IDLE: frame_valid=0. Hop boundary → publish → BUSY.
- Publish timing: frame_valid and initial_address update on the cycle after the boundary write.
- Overrun: in BUSY, the write that makes guard_cnt = N−MAX_TAU+1 sets overrun. It stays set until reset.
- Simultaneous events:
  - frame_ack in the same cycle as a publish: the publish wins; frame_valid stays 1 with the new address and frame_dropped does not pulse.
  - frame_ack while not in BUSY is ignored.
- Reset values:
  - data_out=0, initial_address=0, frame_valid=0, frame_dropped=0, overrun=0.
  - wr_ptr=0, counters=0, state=FILL.
  - Memory contents are not cleared.
  - Reset mid-BUSY discards the frame; a full 2N fresh writes are needed before the next frame.

Optional Feature:
- Macro: YIN_SAMPLE_BUFFER_HOLD_EN.
- Defined:
  - In BUSY, once guard_cnt reaches N−MAX_TAU, further writes are dropped: memory, wr_ptr and the hop counter stay unchanged.
  - overrun is set on the first dropped write.
  - No further hop boundary can occur, so frame_dropped never pulses.
  - Writes resume after frame_ack.
- Undefined: writes always proceed and may overwrite protected data; overrun flags the overwrite.

Test Plan:
All scenarios use WINDOW_SIZE_BITS=4 (N=16, BUF=32), MAX_TAU=4, so FRAME_LEN=20 and guard=12.
1. Reset, then write values 0..31 → frame_valid=1 the cycle after the 32nd write, initial_address=12; read address 12 → data_out=12 next cycle; frame_valid stays 0 through the first 31 writes.
2. After scenario 1, read addresses 31 then 32 → data_out=31 then 0; address 0x0045 → data_out=5.
3. Pulse frame_ack, then write 32..47 → frame_valid falls the cycle after ack and re-rises with initial_address=28; reading addresses 28..47 returns 28..31, then 32..47 from entries 0..15.
4. Publish with no ack, then 13 writes → overrun=1 after the 13th write. Without the macro, entry 12 now holds the new value. With the macro, the 13th write is dropped and entry 12 is unchanged.
5. Without the macro: publish with no ack, then 16 writes → one frame_dropped pulse; frame_valid stays 1; initial_address advances by 16 mod 32.
6. Reset during BUSY → all outputs 0 next cycle; 31 writes give no frame; the 32nd write publishes initial_address=12.
